// File: rtl/divseq_pkg.sv
// Shared types for the iterative divide/remainder sequencer: op encoding,
// FSM states and the W-variant operand width.
package divseq_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  localparam int unsigned WORD_W = 32;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/divseq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when the partial remainder allows it, and emit the quotient bit.
module divseq_step #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_i < divisor_i always holds, so a non-negative diff fits in W bits
  // and bit W of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, msb_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[W];
    rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divide/remainder unit with valid/ready request
// and result handshakes. Define DIVSEQ_EARLY_OUT_EN to skip iterations when
// |dividend| < |divisor|.
module div_sequencer
  import divseq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic [4:0]      in_dest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_dest,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_w(input logic [WORD_W-1:0] v);
    return {{(XLEN-WORD_W){v[WORD_W-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [WORD_W-1:0] v);
    return {{(XLEN-WORD_W){1'b0}}, v};
  endfunction

  state_e          state_q, state_d;
  div_op_e         op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [4:0]      dest_q, dest_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic            signed_op, rem_op;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_sx, a_load;
  logic            a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  divseq_step #(.W(XLEN)) u_step (
    .rem_i     (rem_q),
    .msb_i     (a_q[XLEN-1]),
    .divisor_i (b_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Operand conditioning for PREP; W-variant dividends are left-aligned so
  // the step always consumes a_q's MSB and the quotient lands in the low bits.
  always_comb begin
    signed_op = is_signed_op(op_q);
    rem_op    = is_rem_op(op_q);
    a_ext     = word_q ? (signed_op ? sext_w(a_q[WORD_W-1:0]) : zext_w(a_q[WORD_W-1:0])) : a_q;
    b_ext     = word_q ? (signed_op ? sext_w(b_q[WORD_W-1:0]) : zext_w(b_q[WORD_W-1:0])) : b_q;
    a_neg     = signed_op & a_ext[XLEN-1];
    b_neg     = signed_op & b_ext[XLEN-1];
    a_abs     = a_neg ? -a_ext : a_ext;
    b_abs     = b_neg ? -b_ext : b_ext;
    a_sx      = word_q ? sext_w(a_q[WORD_W-1:0]) : a_q;
    a_load    = word_q ? (a_abs << (XLEN - WORD_W)) : a_abs;
    div_zero  = word_q ? (b_q[WORD_W-1:0] == '0) : (b_q == '0);
    ovf       = signed_op &
                (word_q ? ((a_q[WORD_W-1:0] == {1'b1, {(WORD_W-1){1'b0}}}) && (b_q[WORD_W-1:0] == '1))
                        : ((a_q == MIN_X) && (b_q == '1)));
    q_fix     = qneg_q ? -a_q : a_q;
    r_fix     = rneg_q ? -rem_q : rem_q;
    sel_fix   = rem_op ? r_fix : q_fix;
    fix_res   = word_q ? sext_w(sel_fix[WORD_W-1:0]) : sel_fix;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dest_d  = dest_q;
    res_d   = res_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = div_op_e'(in_op);
          word_d  = in_word;
          a_d     = in_dividend;
          b_d     = in_divisor;
          dest_d  = in_dest;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        a_d    = a_load;
        b_d    = b_abs;
        rem_d  = '0;
        cnt_d  = word_q ? CW'(WORD_W - 1) : CW'(XLEN - 1);
        if (div_zero) begin
          res_d   = rem_op ? a_sx : '1;
          state_d = S_DONE;
        end else if (ovf) begin
          res_d   = rem_op ? '0 : a_sx;
          state_d = S_DONE;
`ifdef DIVSEQ_EARLY_OUT_EN
        end else if (a_abs < b_abs) begin
          res_d   = rem_op ? a_sx : '0;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        a_d   = {a_q[XLEN-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIXUP: begin
        res_d   = fix_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_DIV;
      word_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dest_q      <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      word_q      <= word_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dest_q      <= dest_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_dest   = dest_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected result, dest and latency are
// queued at issue and compared when out_valid rises.
module tb_div_sequencer;

  logic        clk, reset_n, flush, in_valid, in_ready, in_word;
  logic [1:0]  in_op;
  logic [63:0] in_dividend, in_divisor, out_result;
  logic [4:0]  in_dest, out_dest;
  logic        out_valid, out_ready, busy;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  dest;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div_sequencer #(.XLEN(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_word     (in_word),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dest    (out_dest),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  `ifdef DIVSEQ_EARLY_OUT_EN
  localparam int EARLY = 1;
  `else
  localparam int EARLY = 0;
  `endif

  // Reference built on the language's own / and % operators.
  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    logic        sg, rm;
    logic [63:0] r, ua, ub;
    logic [31:0] a32, b32, r32;
    sg = (op == 2'd0) || (op == 2'd2);
    rm = op[1];
    ua = '0;
    ub = '0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      lat = 34;
      if (b32 == 0) begin
        r32 = rm ? a32 : 32'hFFFF_FFFF;
        lat = 1;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        r32 = rm ? 32'h0 : a32;
        lat = 1;
      end else if (sg) begin
        r32 = rm ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
        ua  = {32'h0, a32[31] ? 32'(-a32) : a32};
        ub  = {32'h0, b32[31] ? 32'(-b32) : b32};
      end else begin
        r32 = rm ? a32 % b32 : a32 / b32;
        ua  = {32'h0, a32};
        ub  = {32'h0, b32};
      end
      r = {{32{r32[31]}}, r32};
    end else begin
      lat = 66;
      if (b == 0) begin
        r   = rm ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 1;
      end else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        r   = rm ? 64'h0 : a;
        lat = 1;
      end else if (sg) begin
        r  = rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        ua = a[63] ? -a : a;
        ub = b[63] ? -b : b;
      end else begin
        r  = rm ? a % b : a / b;
        ua = a;
        ub = b;
      end
    end
    if (EARLY == 1 && lat != 1 && ua < ub) lat = 1;
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] d,
                      input logic [63:0] exp_res, input int exp_lat);
    exp_t e;
    @(posedge clk); #1;
    in_op = op; in_word = w; in_dividend = a; in_divisor = b; in_dest = d;
    in_valid = 1'b1;
    e.res = exp_res; e.dest = d; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // n = index of the edge (accepting edge is 0) after which out_valid rose.
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy, out_dest, out_result} !== {1'b1, 1'b0, 1'b0, 5'd0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b vld=%b busy=%b dest=%0d res=%h want 1 0 0 0 0",
               in_ready, out_valid, busy, out_dest, out_result);
    end
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_div64();
    int n; exp_t e;
    send(2'd0, 1'b0, -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL div64_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    wait_valid(n);
    e = sb.pop_front();
    n_checks++;
    if (n !== e.lat) begin n_fail++; $display("FAIL div64_latency got %0d want %0d", n, e.lat); end
    n_checks++;
    if (out_result !== e.res) begin n_fail++; $display("FAIL div64_result got %h want %h", out_result, e.res); end
    n_checks++;
    if (out_dest !== e.dest) begin n_fail++; $display("FAIL div64_dest got %0d want %0d", out_dest, e.dest); end
    take();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL div64_taken got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_special();
    logic [1:0]  ops[4];
    logic        ws[4];
    logic [63:0] as[4], bs[4], rs[4];
    int n; exp_t e;
    ops = '{2'd3, 2'd1, 2'd0, 2'd2};
    ws  = '{1'b0, 1'b0, 1'b1, 1'b1};
    as  = '{64'd100, 64'd100, 64'h8000_0000, 64'h8000_0000};
    bs  = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    rs  = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], ws[i], as[i], bs[i], 5'(i + 9), rs[i], 1);
      wait_valid(n);
      e = sb.pop_front();
      n_checks++;
      if (n !== e.lat) begin n_fail++; $display("FAIL special%0d_latency got %0d want %0d", i, n, e.lat); end
      n_checks++;
      if (out_result !== e.res || out_dest !== e.dest) begin
        n_fail++;
        $display("FAIL special%0d_result got %h/%0d want %h/%0d", i, out_result, out_dest, e.res, e.dest);
      end
      take();
    end
  endtask

  task automatic test_word_hold();
    int n; exp_t e;
    send(2'd1, 1'b1, 64'hFFFF_FFFE, 64'd1, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    wait_valid(n);
    e = sb.pop_front();
    n_checks++;
    if (n !== e.lat) begin n_fail++; $display("FAIL divuw_latency got %0d want %0d", n, e.lat); end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_dest !== e.dest || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL divuw_hold%0d got vld=%b res=%h dest=%0d rdy=%b want 1 %h %0d 0",
                 c, out_valid, out_result, out_dest, in_ready, e.res, e.dest);
      end
      @(posedge clk); #1;
    end
    take();
  endtask

  task automatic test_flush_reset();
    int n;
    send(2'd2, 1'b0, 64'd1000, 64'd7, 5'd3, 64'd6, 66);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sb.pop_front());
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    // flush beats a simultaneous request in IDLE
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_vs_valid got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    send(2'd0, 1'b0, 64'd12345, 64'd11, 5'd21, 64'd1122, 66);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_checks++;
    if ({in_ready, out_valid, busy, out_dest, out_result} !== {1'b1, 1'b0, 1'b0, 5'd0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_midcalc got rdy=%b vld=%b busy=%b dest=%0d res=%h want 1 0 0 0 0",
               in_ready, out_valid, busy, out_dest, out_result);
    end
    #2 reset_n = 1'b1;
    wait_valid(n);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_abort got vld=%b want 0", out_valid); end
  endtask

  task automatic test_early_out();
    int n; exp_t e;
    send(2'd2, 1'b0, -64'sd3, 64'd10, 5'd30, 64'hFFFF_FFFF_FFFF_FFFD, (EARLY == 1) ? 1 : 66);
    wait_valid(n);
    e = sb.pop_front();
    n_checks++;
    if (n !== e.lat) begin n_fail++; $display("FAIL early_latency got %0d want %0d", n, e.lat); end
    n_checks++;
    if (out_result !== e.res) begin n_fail++; $display("FAIL early_result got %h want %h", out_result, e.res); end
    take();
  endtask

  task automatic test_back_to_back();
    int n, lat; exp_t e;
    logic [1:0] op; logic w; logic [63:0] a, b, r;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom(), $urandom()};
      case (i % 4)
        0: b = {$urandom(), $urandom()};
        1: b = 64'($urandom_range(1, 1000));
        2: b = -64'($urandom_range(1, 50));
        default: b = (i == 3) ? 64'd0 : {32'h0, $urandom()};
      endcase
      if (i == 7) a = 64'd5;
      r = model(op, w, a, b, lat);
      send(op, w, a, b, 5'(i), r, lat);
      wait_valid(n);
      e = sb.pop_front();
      n_checks++;
      if (n !== e.lat || out_result !== e.res || out_dest !== e.dest) begin
        n_fail++;
        $display("FAIL b2b%0d op=%0d w=%b a=%h b=%h got %h/%0d lat %0d want %h/%0d lat %0d",
                 i, op, w, a, b, out_result, out_dest, n, e.res, e.dest, e.lat);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    flush = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0;
    in_dividend = '0; in_divisor = '0; in_dest = '0; out_ready = 1'b0;
    test_reset();
    test_div64();
    test_special();
    test_word_hold();
    test_flush_reset();
    test_early_out();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
